bus_txn_master: RTL

//   Control-side transaction initiator for the shared 8-bit crypto data bus.
//   - Accepts a command (src, dst, op, length) and drives the header byte into
//     the control node's data_bus send port (source_id 2'b11).
//   - Counts the payload bytes that the source module then streams.
//   - Pulses ack to close the transfer, which releases bus ownership on every node.

---
 rtl/bus_txn_master.sv | 113 +++++++++++
 1 files changed

// File: rtl/bus_txn_master.sv
// bus_txn_master: control-side initiator that sends a header byte, counts payload bytes and pulses ack.
// Define BUS_CHECKSUM_EN to accumulate an XOR checksum of the counted payload bytes on csum.
module bus_txn_master #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_src,
    input  logic [1:0]       cmd_dst,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             send_valid,
    output logic [7:0]       send_data,
    input  logic             send_ready,
    output logic             ack,
    input  logic             recv_valid,
    input  logic [7:0]       recv_data,
    output logic             busy,
    output logic [LEN_W-1:0] byte_cnt,
    output logic             done,
    output logic             err_timeout,
    output logic [7:0]       csum
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // Timer reaching this value on an idle cycle puts ack TIMEOUT_CYC cycles after the last activity
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 2);

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic [TW-1:0]    timer;
    logic [LEN_W-1:0] cnt_inc;

    assign cnt_inc = byte_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            send_valid  <= 1'b0;
            send_data   <= '0;
            ack         <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            byte_cnt    <= '0;
            len         <= '0;
            timer       <= '0;
        end else begin
            ack         <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    state      <= S_HDR;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b1;
                    send_valid <= 1'b1;
                    send_data  <= {cmd_op, cmd_dst, cmd_src, 2'b00};
                    len        <= cmd_len;
                    byte_cnt   <= '0;
                    timer      <= '0;
                end
                S_HDR: if (send_ready) begin
                    send_valid <= 1'b0;
                    state      <= (len == '0) ? S_ACK : S_XFER;
                    ack        <= (len == '0);
                    done       <= (len == '0);
                end
                S_XFER: if (recv_valid) begin
                    byte_cnt <= cnt_inc;
                    timer    <= '0;
                    if (cnt_inc == len) begin
                        state <= S_ACK;
                        ack   <= 1'b1;
                        done  <= 1'b1;
                    end
                end else if (timer == T_LAST) begin
                    state       <= S_ACK;
                    ack         <= 1'b1;
                    done        <= 1'b1;
                    err_timeout <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && cmd_valid))
            csum <= 8'h00;
        else if (state == S_XFER && recv_valid)
            csum <= csum ^ recv_data;
    end
`else
    logic unused_recv;
    assign unused_recv = ^recv_data;
    assign csum = 8'h00;
`endif
endmodule
